// File: rtl/sendword_pkg.sv
// rtl/sendword_pkg.sv - shared state encoding and frame field order for the sendword link
package sendword_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_RECOVER
   } sendword_state_t;

   // Order in which fields appear on the line, first to last
   typedef enum logic [1:0] {
      FLD_START,
      FLD_MSB,
      FLD_LSB,
      FLD_STOP
   } sendword_field_t;

   localparam int unsigned WORD_BITS   = 2;
   localparam logic        LINE_IDLE   = 1'b0;
   localparam logic        START_LEVEL = 1'b1;
   localparam logic        STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for one asynchronous bit, resets to 0
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sendword_rx.sv
// rtl/sendword_rx.sv - receiver for the 2-bit sendword serial frame, centre-sampled
module sendword_rx
   import sendword_pkg::*;
#(
   parameter int CLKS_PER_BIT = 50000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 in,
   output logic [WORD_BITS-1:0] word,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic                  in_s;
   sendword_state_t       state_q, state_d;
   sendword_field_t       field_q, field_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WORD_BITS-1:0]  shreg_q, shreg_d;
   logic [WORD_BITS-1:0]  word_q, word_d;
   logic                  valid_q, valid_d;
   logic                  frame_err_q, frame_err_d;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .d     (in),
      .q     (in_s)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         field_q     <= FLD_START;
         cnt_q       <= '0;
         shreg_q     <= '0;
         word_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         field_q     <= field_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         word_q      <= word_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Start is sampled half a period in; every later sample is one full period on
   always_comb begin
      state_d     = state_q;
      field_d     = field_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      word_d      = word_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_s == START_LEVEL) begin
               state_d = ST_START;
               field_d = FLD_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (in_s == START_LEVEL) begin
                  state_d = ST_DATA;
                  field_d = FLD_MSB;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shreg_d = {shreg_q[WORD_BITS-2:0], in_s};
               if (field_q == FLD_LSB) begin
                  state_d = ST_STOP;
                  field_d = FLD_STOP;
               end else begin
                  field_d = FLD_LSB;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (in_s == STOP_LEVEL) begin
                  word_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_RECOVER;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RECOVER: begin
            // Wait for the line to go idle so a stuck-high stop is not taken as a start
            if (in_s == LINE_IDLE) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign word      = word_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/sendword_rx.md
SENDWORD_RX -- requirements
Module: sendword_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 50000, sysclk cycles per serial bit period; legal range 4..2^20, even values only.
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2..3.
REQ-003 sysclk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  1  asynchronous serial line driven by the sendword transmitter.
REQ-006 word  output  2  last correctly received word; held until the next good frame.
REQ-007 valid  output  1  one-cycle pulse when word updates.
REQ-008 frame_err  output  1  one-cycle pulse on a stop-bit violation.
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 Frame format on in: idle low; start bit high; data bit 1 (MSB), then data bit 0; stop bit low; each bit lasts CLKS_PER_BIT cycles.
REQ-011 in SHALL pass through SYNC_STAGES flops to give in_s; all decisions use in_s only.
REQ-012 States SHALL be IDLE, START, DATA, STOP and RECOVER; the state after reset is IDLE.
REQ-013 IDLE: when in_s=1, go to START and clear the bit counter.
REQ-014 START: at count CLKS_PER_BIT/2-1, sample in_s; 1 -> DATA with counter cleared and bit index 0; 0 -> IDLE (glitch reject, no pulse).
REQ-015 DATA: at count CLKS_PER_BIT-1, shift in_s into a 2-bit shift register MSB-first and clear the counter; after the second bit, go to STOP.
REQ-016 Samples SHALL fall at bit centre: the start sample is at half a period, and later samples are whole periods after that.
REQ-017 STOP: at count CLKS_PER_BIT-1, sample in_s; 0 -> load word from the shift register, pulse valid, go to IDLE.
REQ-018 STOP: if the sample is 1 -> pulse frame_err, leave word unchanged, go to RECOVER.
REQ-019 RECOVER: remain until in_s=0, then go to IDLE; no new frame starts from RECOVER.
REQ-020 valid and frame_err SHALL never be high in the same cycle, and each is high for exactly one cycle per frame.
REQ-021 Latency: valid asserts in the cycle after the stop-bit sample edge; the output is registered.
REQ-022 The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap; it is cleared on every state transition.
REQ-023 A frame starting on the cycle after valid (back-to-back frames) SHALL be received without loss.
REQ-024 Line activity during DATA or STOP SHALL not alter timing; only centre samples matter.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force: state IDLE, counter 0, shift register 0, word 2'b00, valid 0, frame_err 0, busy 0, synchronizer flops 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no pulse.
REQ-027 After deassertion, a line held high SHALL be treated as a new start edge once SYNC_STAGES cycles have passed.

Structure
REQ-028 State encoding constants and the frame field order (start, MSB, LSB, stop) SHALL live in a shared package, sendword_pkg, also used by sendword.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_bit, parameterised by SYNC_STAGES with an rst_n reset value of 0.
REQ-030 The total RTL SHALL be a single FSM with one counter; no other sub-modules.

Verification (CLKS_PER_BIT=8, SYNC_STAGES=2)
REQ-031 Send frame 1,1,0,0 (start, MSB=1, LSB=0, stop) -> word=2'b10, one valid pulse, busy low afterwards.
REQ-032 Send all four words back-to-back with no idle gap -> word sequence 00,01,10,11 and exactly 4 valid pulses.
REQ-033 Drive a 3-cycle high glitch on in -> return to IDLE, no valid, no frame_err, word unchanged.
REQ-034 Send a frame with the stop bit held high for 20 cycles -> one frame_err pulse, word unchanged, busy high until in_s falls.
REQ-035 Assert rst_n during the DATA bit of a 2'b11 frame -> all outputs 0 at once; the next good frame 2'b01 is received correctly.
REQ-036 Send a frame with a ±1-cycle bit-edge jitter -> the correct word is still received, since centre sampling holds.
